// File: rtl/serial_det_arbiter.sv
// Round-robin scheduler that lends one serial 01110 detector to NREQ parallel clients:
// capture the granted word, clear the detector, stream it MSB-first, count matches, report.
module serial_det_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNTW  = 4,
   parameter int IDW   = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*WIDTH-1:0] DATA,
   output logic [NREQ-1:0]       GNT,
   output logic                  DONE,
   output logic [CNTW-1:0]       HIT_CNT,
   output logic [IDW-1:0]        DONE_ID,
   output logic                  DET_A,
   output logic                  DET_RESET,
   input  logic                  DET_Y
);

   localparam int BCW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      DRAIN,
      REPORT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win_idx;
   logic [WIDTH-1:0] shreg;
   logic [BCW-1:0]   bitcnt;
   logic [CNTW-1:0]  hit;
   logic [CNTW-1:0]  hit_next;
   logic             sample;

   // Walk the search order backwards so the last hit written is the first after ptr.
   always_comb begin
      win_idx = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         if (REQ[(int'(ptr) + k) % NREQ]) begin
            win_idx = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   // DET_Y lags DET_A by one cycle, so the first SHIFT cycle has nothing to sample yet.
   assign sample   = ((state == SHIFT) && (bitcnt != '0)) || (state == DRAIN);
   assign hit_next = (sample && DET_Y && (hit != '1)) ? hit + CNTW'(1) : hit;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      DONE       = 1'b0;
      DET_A      = 1'b0;
      DET_RESET  = RESET;
      case (state)
         IDLE: begin
            if (|REQ) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            DET_RESET  = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            DET_A = shreg[WIDTH-1];
            if (bitcnt == BCW'(WIDTH - 1)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = REPORT;
         end
         REPORT: begin
            DONE       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pointer starts at the last requester so requester 0 wins first after reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         GNT     <= '0;
         ptr     <= IDW'(NREQ - 1);
         shreg   <= '0;
         bitcnt  <= '0;
         hit     <= '0;
         HIT_CNT <= '0;
         DONE_ID <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|REQ) begin
                  GNT   <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                  ptr   <= win_idx;
                  shreg <= DATA[int'(win_idx)*WIDTH +: WIDTH];
                  hit   <= '0;
               end
            end
            CLEAR: begin
               bitcnt <= '0;
            end
            SHIFT: begin
               shreg  <= shreg << 1;
               bitcnt <= bitcnt + BCW'(1);
               hit    <= hit_next;
            end
            DRAIN: begin
               hit     <= hit_next;
               HIT_CNT <= hit_next;
               DONE_ID <= ptr;
            end
            REPORT: begin
               GNT <= '0;
            end
            default: begin
               GNT <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_det_arbiter.sv
// Scoreboard bench for serial_det_arbiter: directed words with hand-computed 01110 hit counts,
// a behavioural Moore detector on each DET_* port, and a negedge monitor popping expectations on DONE.
module tb_serial_det_arbiter;

   typedef struct {
      int id;
      int cnt;
      int cyc;
   } expT;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  REQ;
   logic [31:0] DATA;
   logic [3:0]  GNT;
   logic        DONE;
   logic [3:0]  HIT_CNT;
   logic [1:0]  DONE_ID;
   logic        DET_A;
   logic        DET_RESET;
   logic        DET_Y;

   logic [1:0]  req16;
   logic [31:0] data16;
   logic [1:0]  gnt16a, gnt16b;
   logic        done16a, done16b;
   logic [3:0]  hit16a;
   logic [0:0]  hit16b;
   logic [0:0]  id16a, id16b;
   logic        deta16a, deta16b, detr16a, detr16b, dety16a, dety16b;

   logic [2:0]  det8, det16a, det16b;

   expT q8[$], qa[$], qb[$];
   expT e8, ea, eb;
   int  compared = 0;
   int  mismatched = 0;
   int  cyc = 0;

   serial_det_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(4), .IDW(2)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .DATA(DATA), .GNT(GNT), .DONE(DONE),
      .HIT_CNT(HIT_CNT), .DONE_ID(DONE_ID), .DET_A(DET_A), .DET_RESET(DET_RESET), .DET_Y(DET_Y)
   );

   serial_det_arbiter #(.NREQ(2), .WIDTH(16), .CNTW(4), .IDW(1)) dut16a (
      .CLK(CLK), .RESET(RESET), .REQ(req16), .DATA(data16), .GNT(gnt16a), .DONE(done16a),
      .HIT_CNT(hit16a), .DONE_ID(id16a), .DET_A(deta16a), .DET_RESET(detr16a), .DET_Y(dety16a)
   );

   serial_det_arbiter #(.NREQ(2), .WIDTH(16), .CNTW(1), .IDW(1)) dut16b (
      .CLK(CLK), .RESET(RESET), .REQ(req16), .DATA(data16), .GNT(gnt16b), .DONE(done16b),
      .HIT_CNT(hit16b), .DONE_ID(id16b), .DET_A(deta16b), .DET_RESET(detr16b), .DET_Y(dety16b)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Overlapping 01110 Moore detector: state = length of matched prefix, 5 = match.
   function automatic logic [2:0] detNext(input logic [2:0] s, input logic a);
      case (s)
         3'd0:    detNext = a ? 3'd0 : 3'd1;
         3'd1:    detNext = a ? 3'd2 : 3'd1;
         3'd2:    detNext = a ? 3'd3 : 3'd1;
         3'd3:    detNext = a ? 3'd4 : 3'd1;
         3'd4:    detNext = a ? 3'd0 : 3'd5;
         3'd5:    detNext = a ? 3'd2 : 3'd1;
         default: detNext = 3'd0;
      endcase
   endfunction

   always @(posedge CLK) begin
      det8   <= DET_RESET ? 3'd0 : detNext(det8, DET_A);
      det16a <= detr16a   ? 3'd0 : detNext(det16a, deta16a);
      det16b <= detr16b   ? 3'd0 : detNext(det16b, deta16b);
   end

   assign DET_Y   = (det8 == 3'd5);
   assign dety16a = (det16a == 3'd5);
   assign dety16b = (det16b == 3'd5);

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data);
      REQ  = req;
      DATA = data;
   endtask

   // Returns at the negedge of the CLEAR cycle that follows the grant edge.
   task automatic waitGrant(input int expId, input int expCnt, input bit push);
      int  n;
      expT e;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (GNT == 4'b0 && n < 40);
      if (GNT == 4'b0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL grant timeout: GNT=0, expected %0d", 1 << expId);
      end else begin
         checkOutput("GNT", GNT, 1 << expId);
         checkOutput("DET_RESET in CLEAR", DET_RESET, 1);
         if (push) begin
            e.id  = expId;
            e.cnt = expCnt;
            e.cyc = cyc + 10;
            q8.push_back(e);
         end
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (GNT != 4'b0 && n < 40);
      if (GNT != 4'b0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL idle timeout: GNT=%0d, expected 0", GNT);
      end
   endtask

   // DONE monitor: every DONE cycle must match the oldest pending expectation.
   always @(negedge CLK) begin
      if (DONE) begin
         if (q8.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected DONE: HIT_CNT=%0d DONE_ID=%0d, expected no DONE", HIT_CNT, DONE_ID);
         end else begin
            e8 = q8.pop_front();
            checkOutput("DONE_ID", DONE_ID, e8.id);
            checkOutput("HIT_CNT", HIT_CNT, e8.cnt);
            checkOutput("DONE cycle", cyc, e8.cyc);
            checkOutput("GNT at DONE", GNT, 1 << e8.id);
         end
      end
      if (done16a) begin
         if (qa.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected DONE w16: HIT_CNT=%0d, expected no DONE", hit16a);
         end else begin
            ea = qa.pop_front();
            checkOutput("w16 DONE_ID", id16a, ea.id);
            checkOutput("w16 HIT_CNT", hit16a, ea.cnt);
            checkOutput("w16 DONE cycle", cyc, ea.cyc);
         end
      end
      if (done16b) begin
         if (qb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected DONE w16c1: HIT_CNT=%0d, expected no DONE", hit16b);
         end else begin
            eb = qb.pop_front();
            checkOutput("w16c1 DONE_ID", id16b, eb.id);
            checkOutput("w16c1 HIT_CNT saturated", hit16b, eb.cnt);
            checkOutput("w16c1 DONE cycle", cyc, eb.cyc);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL global timeout: simulation still running at cycle %0d, expected finish", cyc);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int  n;
      expT e;
      RESET  = 1'b1;
      REQ    = 4'b0;
      DATA   = 32'h0;
      req16  = 2'b0;
      data16 = 32'h0;
      repeat (2) @(negedge CLK);

      checkOutput("reset GNT", GNT, 0);
      checkOutput("reset DONE", DONE, 0);
      checkOutput("reset HIT_CNT", HIT_CNT, 0);
      checkOutput("reset DONE_ID", DONE_ID, 0);
      checkOutput("reset DET_A", DET_A, 0);
      checkOutput("reset DET_RESET", DET_RESET, 1);
      RESET = 1'b0;
      @(negedge CLK);
      checkOutput("idle DET_RESET", DET_RESET, 0);

      // Single requester, match mid-word, then last-bit match and no-match words.
      applyStimulus(4'b0001, 32'h00FF_0E70);
      waitGrant(0, 1, 1'b1);
      REQ = 4'b0;
      waitIdle();
      applyStimulus(4'b0001, 32'h0000_000E);
      waitGrant(0, 1, 1'b1);
      REQ = 4'b0;
      waitIdle();
      applyStimulus(4'b0001, 32'h0000_00FF);
      waitGrant(0, 0, 1'b1);
      REQ = 4'b0;
      waitIdle();
      applyStimulus(4'b0001, 32'h0000_0000);
      waitGrant(0, 0, 1'b1);
      REQ = 4'b0;
      waitIdle();

      // Round-robin order from reset, then with all four held.
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      applyStimulus(4'b1010, 32'h00FF_0E70);
      waitGrant(1, 1, 1'b1);
      waitIdle();
      waitGrant(3, 0, 1'b1);
      REQ = 4'b1111;
      waitIdle();
      waitGrant(0, 1, 1'b1);
      waitIdle();
      waitGrant(1, 1, 1'b1);
      waitIdle();
      waitGrant(2, 0, 1'b1);
      waitIdle();
      waitGrant(3, 0, 1'b1);
      waitIdle();
      waitGrant(0, 1, 1'b1);
      REQ = 4'b0;
      waitIdle();

      // Reset pulse in the middle of SHIFT aborts the transaction.
      applyStimulus(4'b0100, 32'h00FF_0E70);
      waitGrant(2, 0, 1'b0);
      repeat (4) @(negedge CLK);
      RESET = 1'b1;
      REQ   = 4'b0;
      @(negedge CLK);
      checkOutput("abort GNT", GNT, 0);
      checkOutput("abort DET_RESET", DET_RESET, 1);
      checkOutput("abort DONE", DONE, 0);
      RESET = 1'b0;
      repeat (12) @(negedge CLK);

      // Requester 0 wins after reset; its DATA changes after grant, requester 2 drops early.
      applyStimulus(4'b0011, 32'h00FF_0E70);
      waitGrant(0, 1, 1'b1);
      DATA[7:0] = 8'hFF;
      REQ = 4'b0100;
      repeat (3) @(negedge CLK);
      REQ = 4'b0010;
      waitIdle();
      waitGrant(1, 1, 1'b1);
      REQ = 4'b0;
      waitIdle();

      // 16-bit words: three matches, and saturation at 1 with a one-bit counter.
      req16  = 2'b01;
      data16 = 32'h0000_7770;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (gnt16a == 2'b0 && n < 40);
      checkOutput("w16 GNT", gnt16a, 1);
      checkOutput("w16c1 GNT", gnt16b, 1);
      e.id  = 0;
      e.cnt = 3;
      e.cyc = cyc + 18;
      qa.push_back(e);
      e.cnt = 1;
      qb.push_back(e);
      req16 = 2'b0;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (gnt16a != 2'b0 && n < 60);
      checkOutput("w16 GNT released", gnt16a, 0);

      repeat (4) @(negedge CLK);
      checkOutput("pending DONE w8", q8.size(), 0);
      checkOutput("pending DONE w16", qa.size(), 0);
      checkOutput("pending DONE w16c1", qb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
